// File: rtl/pipe_fde_if.sv
// pipe_fde_if: hazard/decode side (master) to fetch/decode/execute register bank (slave)
interface pipe_fde_if #(parameter int CNT_W = 16);
  logic Stall_F, Stall_D, Flush_E, PCSrc_D;
  logic [31:0] PC_Branch_D, PC_F, Instr_F, Instr_D, PC_Plus4_D;
  logic Valid_D, Valid_E;
  logic RegWrite_D, MemtoReg_D, MemWrite_D, ALUSrc_D, RegDst_D;
  logic [2:0] ALUControl_D;
  logic [31:0] RD1_D, RD2_D, SignImm_D;
  logic [4:0] Rs_D, Rt_D, Rd_D;
  logic RegWrite_E, MemtoReg_E, MemWrite_E, ALUSrc_E, RegDst_E;
  logic [2:0] ALUControl_E;
  logic [31:0] RD1_E, RD2_E, SignImm_E;
  logic [4:0] Rs_E, Rt_E, Rd_E;
  logic [CNT_W-1:0] Stall_Cnt, Flush_Cnt;
  modport master (
    output Stall_F, Stall_D, Flush_E, PCSrc_D, PC_Branch_D, Instr_F,
    output RegWrite_D, MemtoReg_D, MemWrite_D, ALUSrc_D, RegDst_D, ALUControl_D,
    output RD1_D, RD2_D, SignImm_D, Rs_D, Rt_D, Rd_D,
    input PC_F, Instr_D, PC_Plus4_D, Valid_D, Valid_E,
    input RegWrite_E, MemtoReg_E, MemWrite_E, ALUSrc_E, RegDst_E, ALUControl_E,
    input RD1_E, RD2_E, SignImm_E, Rs_E, Rt_E, Rd_E, Stall_Cnt, Flush_Cnt
  );
  modport slave (
    input Stall_F, Stall_D, Flush_E, PCSrc_D, PC_Branch_D, Instr_F,
    input RegWrite_D, MemtoReg_D, MemWrite_D, ALUSrc_D, RegDst_D, ALUControl_D,
    input RD1_D, RD2_D, SignImm_D, Rs_D, Rt_D, Rd_D,
    output PC_F, Instr_D, PC_Plus4_D, Valid_D, Valid_E,
    output RegWrite_E, MemtoReg_E, MemWrite_E, ALUSrc_E, RegDst_E, ALUControl_E,
    output RD1_E, RD2_E, SignImm_E, Rs_E, Rt_E, Rd_E, Stall_Cnt, Flush_Cnt
  );
endinterface

// File: rtl/pipe_fde_regs.sv
// pipe_fde_regs: PC, IF/ID and ID/EX registers with stall/flush; PIPE_PERF_CNT_EN adds saturating stall/flush counters
module pipe_fde_regs #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  pipe_fde_if.slave bus
);
  logic br;
  logic [31:0] pc_plus4;
  assign br = bus.PCSrc_D & ~bus.Stall_D;
  assign pc_plus4 = bus.PC_F + 32'd4;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.PC_F <= RESET_PC;
      bus.Instr_D <= '0;
      bus.PC_Plus4_D <= '0;
      bus.Valid_D <= 1'b0;
    end else begin
      if (!bus.Stall_F) bus.PC_F <= br ? bus.PC_Branch_D : pc_plus4;
      if (!bus.Stall_D) begin
        bus.Instr_D <= bus.PCSrc_D ? '0 : bus.Instr_F;
        bus.PC_Plus4_D <= bus.PCSrc_D ? '0 : pc_plus4;
        bus.Valid_D <= ~bus.PCSrc_D;
      end
    end
  always_ff @(posedge clk or posedge rst)
    if (rst)
      {bus.RegWrite_E, bus.MemtoReg_E, bus.MemWrite_E, bus.ALUSrc_E, bus.RegDst_E, bus.ALUControl_E,
       bus.RD1_E, bus.RD2_E, bus.SignImm_E, bus.Rs_E, bus.Rt_E, bus.Rd_E, bus.Valid_E} <= '0;
    else
      {bus.RegWrite_E, bus.MemtoReg_E, bus.MemWrite_E, bus.ALUSrc_E, bus.RegDst_E, bus.ALUControl_E,
       bus.RD1_E, bus.RD2_E, bus.SignImm_E, bus.Rs_E, bus.Rt_E, bus.Rd_E, bus.Valid_E} <= bus.Flush_E ? '0 :
      {bus.RegWrite_D, bus.MemtoReg_D, bus.MemWrite_D, bus.ALUSrc_D, bus.RegDst_D, bus.ALUControl_D,
       bus.RD1_D, bus.RD2_D, bus.SignImm_D, bus.Rs_D, bus.Rt_D, bus.Rd_D, bus.Valid_D};
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bus.Stall_D && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if ((bus.Flush_E || br) && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
    end
  assign bus.Stall_Cnt = stall_cnt;
  assign bus.Flush_Cnt = flush_cnt;
`else
  assign bus.Stall_Cnt = {CNT_W{1'b0}};
  assign bus.Flush_Cnt = {CNT_W{1'b0}};
`endif
endmodule
